// File: rtl/openram_tc_pkg.sv
// rtl/openram_tc_pkg.sv - shared constants and types for the WB SRAM access controller
package openram_tc_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

    // Register offsets within the 256-byte window
    localparam logic [7:0] OFF_ADDR   = 8'h00;
    localparam logic [7:0] OFF_DIN    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_DOUT   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    // CTRL bit positions; WEB carries the SRAM web level (1 = read, 0 = write)
    localparam int CTRL_GO        = 0;
    localparam int CTRL_WEB       = 1;
    localparam int CTRL_WMASK_LSB = 4;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Expand four byte selects into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_reg_if.sv
// rtl/wb_reg_if.sv - WB decode, registered ack, register file with byte-select merging
//
// Ports:
//  clk, resetn             clock, asynchronous active-low reset
//  wbs_*                   Wishbone classic slave interface
//  busy                    access FSM is in DRIVE/WAIT
//  done_set, dout_load     capture-cycle strobes from the access FSM
//  dout_data               SRAM read data to capture into DOUT
//  reg_addr/din/web/wmask  programmed access parameters
//  go                      one-cycle start pulse (accepted GO write)
module wb_reg_if
    import openram_tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    input  logic                  busy,
    input  logic                  done_set,
    input  logic                  dout_load,
    input  logic [DATA_WIDTH-1:0] dout_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_din,
    output logic                  reg_web,
    output logic [NUM_WMASKS-1:0] reg_wmask,
    output logic                  go
);

    logic                  hit;
    logic                  is_cfg;
    logic                  lockout;
    logic [7:0]            off;
    logic [31:0]           bmask;
    logic [31:0]           rdata;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] din_next;
    logic [DATA_WIDTH-1:0] reg_dout;
    logic                  done;
    logic                  err;

    // ~ack keeps a held strobe from producing a second ack
    assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
               & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off    = wbs_adr_i[7:0];
    assign is_cfg = (off == OFF_ADDR) || (off == OFF_DIN) || (off == OFF_CTRL);

    // A pending GO pulse counts as busy so the cycle right after a GO ack
    // cannot slip a config write in before the FSM leaves IDLE.
    assign lockout = busy | go;

    assign bmask     = byte_mask(wbs_sel_i);
    assign addr_next = (reg_addr & ~bmask[ADDR_WIDTH-1:0])
                     | (wbs_dat_i[ADDR_WIDTH-1:0] & bmask[ADDR_WIDTH-1:0]);
    assign din_next  = (reg_din & ~bmask[DATA_WIDTH-1:0])
                     | (wbs_dat_i[DATA_WIDTH-1:0] & bmask[DATA_WIDTH-1:0]);

    always_comb begin
        rdata = '0;
        case (off)
            OFF_ADDR:   rdata[ADDR_WIDTH-1:0] = reg_addr;
            OFF_DIN:    rdata[DATA_WIDTH-1:0] = reg_din;
            OFF_CTRL: begin
                rdata[CTRL_WEB]                         = reg_web;
                rdata[CTRL_WMASK_LSB +: NUM_WMASKS]     = reg_wmask;
            end
            OFF_DOUT:   rdata[DATA_WIDTH-1:0] = reg_dout;
            OFF_STATUS: begin
                rdata[STAT_BUSY] = lockout;
                rdata[STAT_DONE] = done;
                rdata[STAT_ERR]  = err;
            end
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            reg_addr  <= '0;
            reg_din   <= '0;
            reg_web   <= 1'b0;
            reg_wmask <= '0;
            reg_dout  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            go        <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rdata : '0;
            go        <= 1'b0;
            if (hit && wbs_we_i) begin
                if (is_cfg && lockout) begin
                    err <= 1'b1;
                end else begin
                    case (off)
                        OFF_ADDR: reg_addr <= addr_next;
                        OFF_DIN:  reg_din  <= din_next;
                        OFF_CTRL: begin
                            if (wbs_sel_i[0]) begin
                                go        <= wbs_dat_i[CTRL_GO];
                                reg_web   <= wbs_dat_i[CTRL_WEB];
                                reg_wmask <= wbs_dat_i[CTRL_WMASK_LSB +: NUM_WMASKS];
                            end
                        end
                        OFF_STATUS: begin
                            if (wbs_sel_i[0]) begin
                                if (wbs_dat_i[STAT_DONE]) done <= 1'b0;
                                if (wbs_dat_i[STAT_ERR])  err  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Placed after the clear so a same-cycle set wins
            if (done_set)  done     <= 1'b1;
            if (dout_load) reg_dout <= dout_data;
        end
    end

endmodule

// File: rtl/wb_sram_access_ctrl.sv
// rtl/wb_sram_access_ctrl.sv - WB slave running single SRAM port accesses on GO
//
// Ports:
//  clk, resetn     clock, asynchronous active-low reset
//  wbs_*           Wishbone classic slave interface
//  sram_csb/web    SRAM chip select / write enable (active low)
//  sram_wmask      SRAM byte write mask
//  sram_addr/din   SRAM address / write data
//  sram_dout       SRAM read data
//  busy            access in progress
module wb_sram_access_ctrl
    import openram_tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 32,
    parameter int          NUM_WMASKS   = 4,
    parameter int          SRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  busy
);

    localparam logic [3:0] LAT_LOAD = 4'(SRAM_LATENCY - 1);

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic                  web_q;
    logic                  go;
    logic                  done_set;
    logic                  dout_load;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_din;
    logic                  reg_web;
    logic [NUM_WMASKS-1:0] reg_wmask;

    wb_reg_if #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_reg_if (
        .clk        (clk),
        .resetn     (resetn),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .busy       (busy),
        .done_set   (done_set),
        .dout_load  (dout_load),
        .dout_data  (sram_dout),
        .reg_addr   (reg_addr),
        .reg_din    (reg_din),
        .reg_web    (reg_web),
        .reg_wmask  (reg_wmask),
        .go         (go)
    );

    // Decoded from the async-reset state so reset forces csb/web high at once
    assign busy     = (state == ST_DRIVE) || (state == ST_WAIT);
    assign sram_csb = (state != ST_DRIVE);
    assign sram_web = (state == ST_DRIVE) ? web_q : 1'b1;

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        dout_load  = 1'b0;
        case (state)
            ST_IDLE:    if (go) state_next = ST_DRIVE;
            ST_DRIVE:   state_next = ST_WAIT;
            ST_WAIT:    if (cnt == 4'd0) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                done_set   = 1'b1;
                dout_load  = web_q;
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            web_q      <= 1'b1;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_wmask <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && go) begin
                sram_addr  <= reg_addr;
                sram_din   <= reg_din;
                web_q      <= reg_web;
                sram_wmask <= reg_web ? '0 : reg_wmask;
            end
            if (state == ST_DRIVE) begin
                cnt <= LAT_LOAD;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_access_ctrl.sv
// tb/tb_wb_sram_access_ctrl.sv - directed self-checking bench for wb_sram_access_ctrl
module tb_wb_sram_access_ctrl;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [7:0]  R_ADR = 8'h00;
    localparam logic [7:0]  R_DIN = 8'h04;
    localparam logic [7:0]  R_CTL = 8'h08;
    localparam logic [7:0]  R_DOU = 8'h0C;
    localparam logic [7:0]  R_STA = 8'h10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic        ack   [2];
    logic        csb   [2];
    logic        web   [2];
    logic        busy  [2];
    logic [3:0]  sel   [2];
    logic [3:0]  wmask [2];
    logic [31:0] adr   [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic [15:0] saddr [2];
    logic [31:0] mem   [2][256];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        wb_sram_access_ctrl #(.SRAM_LATENCY(g == 0 ? 1 : 3)) dut (
            .clk        (clk),
            .resetn     (resetn),
            .wbs_cyc_i  (cyc[g]),
            .wbs_stb_i  (stb[g]),
            .wbs_we_i   (we[g]),
            .wbs_sel_i  (sel[g]),
            .wbs_adr_i  (adr[g]),
            .wbs_dat_i  (wdat[g]),
            .wbs_ack_o  (ack[g]),
            .wbs_dat_o  (rdat[g]),
            .sram_csb   (csb[g]),
            .sram_web   (web[g]),
            .sram_wmask (wmask[g]),
            .sram_addr  (saddr[g]),
            .sram_din   (din[g]),
            .sram_dout  (dout[g]),
            .busy       (busy[g])
        );
    end

    // Behavioural single-port SRAM: sampled on the clock edge that sees csb low
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!csb[u]) begin
                if (!web[u]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[u][b]) mem[u][saddr[u][7:0]][b*8 +: 8] <= din[u][b*8 +: 8];
                end else begin
                    dout[u] <= mem[u][saddr[u][7:0]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input int u, input logic [7:0] off, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        adr[u] = BASE | {24'd0, off}; wdat[u] = d; sel[u] = s; we[u] = 1'b1;
        cyc[u] = 1'b1; stb[u] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[u] && n < 10);
        if (!ack[u]) check("wr_ack_timeout", 32'(ack[u]), 32'd1);
        cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
    endtask

    task automatic wb_read(input int u, input logic [7:0] off, output logic [31:0] d);
        int n;
        adr[u] = BASE | {24'd0, off}; sel[u] = 4'hF; we[u] = 1'b0;
        cyc[u] = 1'b1; stb[u] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[u] && n < 10);
        if (!ack[u]) check("rd_ack_timeout", 32'(ack[u]), 32'd1);
        d = rdat[u];
        cyc[u] = 1'b0; stb[u] = 1'b0;
    endtask

    // Call right after the GO write returns (negedge of ack cycle T)
    task automatic watch(input int u, input int lat, input logic [15:0] ea,
                         input logic [31:0] ed, input logic ew, input logic [3:0] em);
        int k = 0, low_n = 0, first_low = 0, fall = 0;
        logic b1 = 1'b0, a1 = 1'b1, sw = 1'b1;
        logic [15:0] sa = '0;
        logic [31:0] sd = '0;
        logic [3:0]  sm = '0;
        while (fall == 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin b1 = busy[u]; a1 = ack[u]; end
            if (!csb[u]) begin
                low_n++;
                if (first_low == 0) first_low = k;
                sa = saddr[u]; sd = din[u]; sw = web[u]; sm = wmask[u];
            end
            if (!busy[u] && k > 1) fall = k;
        end
        check("ack_single",    32'(a1), 32'd0);
        check("busy_at_T1",    32'(b1), 32'd1);
        check("csb_low_count", 32'(low_n), 32'd1);
        check("csb_low_at",    32'(first_low), 32'd1);
        check("busy_fall_at",  32'(fall), 32'(2 + lat));
        check("drive_addr",    32'(sa), 32'(ea));
        check("drive_din",     sd, ed);
        check("drive_web",     32'(sw), 32'(ew));
        check("drive_wmask",   32'(sm), 32'(em));
    endtask

    logic [31:0] rv;

    initial begin
        for (int u = 0; u < 2; u++) begin
            cyc[u] = 0; stb[u] = 0; we[u] = 0; sel[u] = 0; adr[u] = 0; wdat[u] = 0;
            for (int i = 0; i < 256; i++) mem[u][i] = 32'h0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csb",   32'(csb[0]), 32'd1);
        check("rst_web",   32'(web[0]), 32'd1);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_ack",   32'(ack[0]), 32'd0);
        check("rst_datao", rdat[0], 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Masked write of the full word
        wb_write(0, R_ADR, 32'h0000_0012, 4'hF);
        wb_write(0, R_DIN, 32'hDEAD_BEEF, 4'hF);
        wb_write(0, R_CTL, 32'h0000_00F1, 4'hF);
        watch(0, 1, 16'h0012, 32'hDEAD_BEEF, 1'b0, 4'hF);
        repeat (2) @(negedge clk);
        check("t2_mem", mem[0][8'h12], 32'hDEAD_BEEF);
        wb_read(0, R_STA, rv); check("t2_status", rv, 32'h2);

        // Read back
        wb_write(0, R_CTL, 32'h0000_0003, 4'hF);
        watch(0, 1, 16'h0012, 32'hDEAD_BEEF, 1'b1, 4'h0);
        repeat (2) @(negedge clk);
        wb_read(0, R_DOU, rv); check("t3_dout", rv, 32'hDEAD_BEEF);
        wb_read(0, R_STA, rv); check("t3_status", rv, 32'h2);
        wb_read(0, R_CTL, rv); check("t3_ctrl_go_clr", rv, 32'h2);
        @(negedge clk);
        check("idle_datao_zero", rdat[0], 32'h0);

        // Partial byte mask 0x5
        wb_write(0, R_DIN, 32'h1122_3344, 4'hF);
        wb_write(0, R_CTL, 32'h0000_0051, 4'hF);
        watch(0, 1, 16'h0012, 32'h1122_3344, 1'b0, 4'h5);
        repeat (2) @(negedge clk);
        check("t4_mem", mem[0][8'h12], 32'hDE22_BE44);
        wb_read(0, R_DOU, rv); check("t4_dout_kept", rv, 32'hDEAD_BEEF);
        wb_write(0, R_CTL, 32'h0000_0003, 4'hF);
        watch(0, 1, 16'h0012, 32'h1122_3344, 1'b1, 4'h0);
        repeat (2) @(negedge clk);
        wb_read(0, R_DOU, rv); check("t4_dout", rv, 32'hDE22_BE44);

        // Config write while busy
        wb_write(0, R_STA, 32'h6, 4'hF);
        wb_write(0, R_CTL, 32'h0000_0003, 4'hF);
        wb_write(0, R_DIN, 32'h5555_5555, 4'hF);
        @(negedge clk);
        check("t5_ack_single", 32'(ack[0]), 32'd0);
        for (int n = 0; n < 20 && busy[0]; n++) @(negedge clk);
        check("t5_busy_done", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        wb_read(0, R_DIN, rv); check("t5_din_kept", rv, 32'h1122_3344);
        wb_read(0, R_STA, rv); check("t5_status_err", rv, 32'h6);
        wb_write(0, R_STA, 32'h6, 4'hF);
        wb_read(0, R_STA, rv); check("t5_status_w1c", rv, 32'h0);

        // Byte-select merge and unmapped offset
        wb_write(0, R_ADR, 32'h0000_3456, 4'b0010);
        wb_read(0, R_ADR, rv); check("sel_merge_addr", rv, 32'h0000_3412);
        wb_write(0, 8'h20, 32'hFFFF_FFFF, 4'hF);
        wb_read(0, 8'h20, rv); check("unmapped_read", rv, 32'h0);

        // Asynchronous reset in the middle of WAIT
        wb_write(0, R_ADR, 32'h0000_0012, 4'hF);
        wb_write(0, R_CTL, 32'h0000_0003, 4'hF);
        repeat (2) @(negedge clk);
        check("t1_busy_pre", 32'(busy[0]), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t1_csb",   32'(csb[0]), 32'd1);
        check("t1_busy",  32'(busy[0]), 32'd0);
        check("t1_ack",   32'(ack[0]), 32'd0);
        check("t1_addr",  32'(saddr[0]), 32'h0);
        check("t1_wmask", 32'(wmask[0]), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        wb_read(0, R_ADR, rv); check("t1_reg_addr", rv, 32'h0);
        wb_read(0, R_DIN, rv); check("t1_reg_din",  rv, 32'h0);
        wb_read(0, R_CTL, rv); check("t1_reg_ctrl", rv, 32'h0);
        wb_read(0, R_DOU, rv); check("t1_reg_dout", rv, 32'h0);
        wb_read(0, R_STA, rv); check("t1_reg_stat", rv, 32'h0);

        // Latency 3, back-to-back GO right after busy falls
        wb_write(1, R_ADR, 32'h0000_0005, 4'hF);
        wb_write(1, R_DIN, 32'hCAFE_F00D, 4'hF);
        wb_write(1, R_CTL, 32'h0000_00F1, 4'hF);
        watch(1, 3, 16'h0005, 32'hCAFE_F00D, 1'b0, 4'hF);
        wb_write(1, R_CTL, 32'h0000_0003, 4'hF);
        watch(1, 3, 16'h0005, 32'hCAFE_F00D, 1'b1, 4'h0);
        repeat (2) @(negedge clk);
        wb_read(1, R_STA, rv); check("t6_status", rv, 32'h2);
        wb_read(1, R_DOU, rv); check("t6_dout", rv, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
